i2s_rx: RTL

Oversampling I2S receiver for the codec ADC path: recovers signed BITSIZE-bit left/right samples from ADCDAT using the codec-driven BCLK and ADCLRC. It is the receive counterpart of i2s_tx and feeds captured audio into the effect/mixer chain. All logic runs in the single fabric clock `clk`; BCLK, LRCLK and SDATA are treated as asynchronous inputs and sampled.

---
 rtl/i2s_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// Oversampling I2S receiver: recovers signed BITSIZE-bit left/right samples from
// an asynchronous BCLK/LRCLK/SDATA triple, presenting each left-then-right pair with a valid pulse.
module i2s_rx #(
  parameter int BITSIZE = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
  output logic               frame_err
);

  localparam int CW = $clog2(BITSIZE + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

  // Bit order in the synchronizer vectors: [0] bclk, [1] lrclk, [2] sdata
  logic [2:0] async_in;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic       bclk_d3_reg;

  logic       rise_reg;
  logic       lr_s_reg;
  logic       d_s_reg;

  state_t               state_reg, state_next;
  logic [BITSIZE-1:0]   shreg_reg, shreg_next;
  logic [CW-1:0]        bitcnt_reg, bitcnt_next;
  logic                 chan_reg, chan_next;
  logic                 left_ok_reg, left_ok_next;
  logic                 lr_prev_reg, lr_prev_next;
  logic [BITSIZE-1:0]   left_hold_reg, left_hold_next;
  logic [BITSIZE-1:0]   left_chan_reg, left_chan_next;
  logic [BITSIZE-1:0]   right_chan_reg, right_chan_next;
  logic                 valid_reg, valid_next;
  logic                 frame_err_reg, frame_err_next;

  assign async_in = {sdata, lrclk, bclk};

  // Synchronizers carry no reset so a reset while BCLK is high cannot fake a rising edge
  always_ff @(posedge clk) begin
    sync1_reg   <= async_in;
    sync2_reg   <= sync1_reg;
    bclk_d3_reg <= sync2_reg[0];
  end

  // Registered edge detect; lrclk/sdata are captured alongside so they stay aligned with rise
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_reg <= 1'b0;
      lr_s_reg <= 1'b0;
      d_s_reg  <= 1'b0;
    end else begin
      rise_reg <= sync2_reg[0] & ~bclk_d3_reg;
      lr_s_reg <= sync2_reg[1];
      d_s_reg  <= sync2_reg[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      bitcnt_reg     <= '0;
      chan_reg       <= 1'b0;
      left_ok_reg    <= 1'b0;
      lr_prev_reg    <= 1'b0;
      left_hold_reg  <= '0;
      left_chan_reg  <= '0;
      right_chan_reg <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      bitcnt_reg     <= bitcnt_next;
      chan_reg       <= chan_next;
      left_ok_reg    <= left_ok_next;
      lr_prev_reg    <= lr_prev_next;
      left_hold_reg  <= left_hold_next;
      left_chan_reg  <= left_chan_next;
      right_chan_reg <= right_chan_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    bitcnt_next     = bitcnt_reg;
    chan_next       = chan_reg;
    left_ok_next    = left_ok_reg;
    lr_prev_next    = lr_prev_reg;
    left_hold_next  = left_hold_reg;
    left_chan_next  = left_chan_reg;
    right_chan_next = right_chan_reg;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;

    if (rise_reg) begin
      lr_prev_next = lr_s_reg;
      if (lr_s_reg != lr_prev_reg) begin
        // The bit on a slot-start edge belongs to the old slot, so it is never shifted
        if (state_reg == SHIFT) begin
          frame_err_next = 1'b1;
        end
        // Only a left slot may bring the receiver out of IDLE
        if (state_reg != IDLE || !lr_s_reg) begin
          state_next  = SHIFT;
          bitcnt_next = '0;
          chan_next   = lr_s_reg;
          if (!lr_s_reg) begin
            left_ok_next = 1'b0;
          end
        end
      end else if (state_reg == SHIFT) begin
        shreg_next  = {shreg_reg[BITSIZE-2:0], d_s_reg};
        bitcnt_next = bitcnt_reg + 1'b1;
        if (bitcnt_reg == CW'(BITSIZE - 1)) begin
          state_next = WAIT;
          if (!chan_reg) begin
            left_hold_next = shreg_next;
            left_ok_next   = 1'b1;
          end else if (left_ok_reg) begin
            left_chan_next  = left_hold_reg;
            right_chan_next = shreg_next;
            valid_next      = 1'b1;
            left_ok_next    = 1'b0;
          end
        end
      end
    end
  end

  assign left_chan  = left_chan_reg;
  assign right_chan = right_chan_reg;
  assign valid      = valid_reg;
  assign frame_err  = frame_err_reg;

endmodule
